// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM for a multicycle MIPS-subset datapath
//   (lw, sw, R-type add/sub/and/or/slt, beq, addi, j).
//   Each instruction takes several states. The FSM drives every datapath
//   select and strobe for the current cycle.
//
// Parameters
//   HALT_ON_ILLEGAL  1: an illegal opcode or funct parks the FSM in HALT.
//                    0: an illegal opcode or funct behaves as a NOP and the
//                       FSM returns to FETCH without writing anything.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous reset, active low
//   opcode       IR[31:26]
//   funct        IR[5:0]
//   zero         ALU zero flag (used by beq)
//   mem_ready    memory access completes this cycle
//   mem_req      memory access request
//   mem_write    store strobe
//   iord         address source: 0 = PC, 1 = ALUOut
//   ir_write     instruction register load
//   pc_en        PC load enable
//   pc_src       next PC: 00 = ALU, 01 = ALUOut, 10 = jump target
//   reg_write    register-file write enable
//   reg_dst      destination: 0 = rt, 1 = rd
//   mem_to_reg   writeback: 0 = ALUOut, 1 = MDR
//   alu_src_a    ALU A: 0 = PC, 1 = rd1
//   alu_src_b    ALU B: 00 = rd2, 01 = 4, 10 = simm, 11 = simm << 2
//   alu_control  ALU operation
//   halted       FSM is in HALT
//   state        current state encoding (debug)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int unsigned HALT_ON_ILLEGAL = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Where an illegal opcode/funct sends the FSM.
    localparam state_t ILLEGAL_NEXT = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;

    state_t state_q;
    state_t state_d;

    // Decoded (pre-reset-gating) versions of the request/enable strobes.
    logic mem_req_dec;
    logic ir_write_dec;
    logic pc_en_dec;

    // R-type funct decode, shared by output and next-state logic.
    logic       funct_legal;
    logic [2:0] funct_alu;

    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = ALU_AND;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = ILLEGAL_NEXT;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = funct_legal ? S_ALUWB : ILLEGAL_NEXT;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;   // unused codes 13..15 recover
        endcase
    end

    // Output decode: everything defaults to 0, each state raises only its own.
    always_comb begin
        mem_req_dec  = 1'b0;
        mem_write    = 1'b0;
        iord         = 1'b0;
        ir_write_dec = 1'b0;
        pc_en_dec    = 1'b0;
        pc_src       = 2'b00;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_control  = 3'b000;
        halted       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_dec  = 1'b1;
                alu_src_b    = 2'b01;
                alu_control  = ALU_ADD;
                // IR and PC load only in the cycle the fetch completes.
                ir_write_dec = mem_ready;
                pc_en_dec    = mem_ready;
            end
            S_DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = ALU_ADD;
            end
            S_MEMADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
            end
            S_MEMRD: begin
                mem_req_dec = 1'b1;
                iord        = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_req_dec = 1'b1;
                iord        = 1'b1;
                mem_write   = 1'b1;
            end
            S_EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                pc_en_dec   = zero;
            end
            S_ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_src    = 2'b10;
                pc_en_dec = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // While reset is held the state is already FETCH, but the fetch must not
    // actually start: suppress the request and both load enables.
    assign mem_req  = mem_req_dec  & reset;
    assign ir_write = ir_write_dec & reset;
    assign pc_en    = pc_en_dec    & reset;

    assign state = state_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one parameter: HALT_ON_ILLEGAL, default 1; 1 means an illegal opcode or funct enters HALT, 0 means it is treated as a NOP and returns to FETCH.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  6  instruction register bits [31:26].
REQ-005 funct  input  6  instruction register bits [5:0].
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory access completes this cycle.
REQ-008 mem_req  output  1  memory access request.
REQ-009 mem_write  output  1  store strobe (we_mem).
REQ-010 iord  output  1  address source; 0 = PC, 1 = ALUOut.
REQ-011 ir_write  output  1  load the instruction register.
REQ-012 pc_en  output  1  PC load enable.
REQ-013 pc_src  output  2  next PC select; 00 = ALU, 01 = ALUOut, 10 = jump target.
REQ-014 reg_write  output  1  register-file write enable (we_reg).
REQ-015 reg_dst  output  1  destination select; 0 = rt, 1 = rd.
REQ-016 mem_to_reg  output  1  writeback select; 0 = ALUOut, 1 = MDR.
REQ-017 alu_src_a  output  1  ALU A select; 0 = PC, 1 = rd1.
REQ-018 alu_src_b  output  2  ALU B select; 00 = rd2, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
REQ-019 alu_control  output  3  ALU operation code.
REQ-020 halted  output  1  controller is in HALT.
REQ-021 state  output  4  current state encoding, for debug.

Function
REQ-022 States and encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=12. Codes 13–15 SHALL go to FETCH on the next edge.
REQ-023 FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00.
  - ir_write and pc_en SHALL be 1 only in a cycle where mem_ready=1.
  - While mem_ready=0: stay in FETCH; ir_write=0, pc_en=0.
REQ-024 DECODE: alu_src_a=0, alu_src_b=11, alu_control=010. Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other -> illegal
REQ-025 MEMADR: alu_src_a=1, alu_src_b=10, alu_control=010. Next state MEMRD for lw, MEMWR for sw.
REQ-026 MEMRD and MEMWR: mem_req=1, iord=1; MEMWR additionally mem_write=1.
  - Hold the state while mem_ready=0.
  - mem_ready=1: MEMRD -> MEMWB; MEMWR -> FETCH.
REQ-027 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; next state FETCH.
REQ-028 EXEC: alu_src_a=1, alu_src_b=00. alu_control by funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - other funct -> illegal, no ALUWB
REQ-029 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; next state FETCH.
REQ-030 BRANCH: alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, pc_en=zero; next state FETCH.
REQ-031 ADDIEX: alu_src_a=1, alu_src_b=10, alu_control=010; next state ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; next state FETCH.
REQ-032 JUMP: pc_src=10, pc_en=1; next state FETCH.
REQ-033 Illegal opcode or funct:
  - HALT_ON_ILLEGAL=1: next state HALT.
  - HALT_ON_ILLEGAL=0: next state FETCH, with no register or memory write.
REQ-034 HALT is absorbing: halted=1, every strobe 0. Only reset exits HALT.
REQ-035 Any output not listed for a state SHALL be 0. Outputs SHALL be decoded from state plus mem_ready, zero and funct only.
REQ-036 A mem_ready pulse outside FETCH, MEMRD and MEMWR SHALL be ignored.
REQ-037 At most one of ir_write, mem_write and reg_write SHALL be 1 in any cycle.

Reset
REQ-038 Asserting reset low SHALL force the state to FETCH immediately, without waiting for a clock edge, including in the middle of any access or in HALT.
REQ-039 While reset=0, every output SHALL be 0 except the FETCH decode, and mem_req, ir_write and pc_en SHALL be held at 0.
REQ-040 The first mem_req SHALL be asserted in the first cycle after reset deasserts.

Verification
REQ-041 R-type add (opcode 000000, funct 100000), mem_ready=1 on the first FETCH cycle -> states 0,1,6,7,0; alu_control=010 in EXEC; reg_write=1 and reg_dst=1 only in ALUWB.
REQ-042 lw with mem_ready held low 3 cycles in FETCH and 2 cycles in MEMRD -> FETCH lasts 4 cycles, MEMRD lasts 3 cycles, one ir_write pulse, one pc_en pulse, then MEMWB with mem_to_reg=1.
REQ-043 beq with zero=1, then beq with zero=0 -> pc_en=1 with pc_src=01 in BRANCH only for the first; both instructions take 3 cycles with mem_ready=1.
REQ-044 sw with mem_ready=1 -> states 0,1,2,5,0; mem_write=1 for exactly 1 cycle with iord=1; reg_write is never asserted.
REQ-045 Opcode 111111 -> with HALT_ON_ILLEGAL=1, state=12 and halted=1 held for 20 cycles, cleared only by reset=0; with HALT_ON_ILLEGAL=0, the next state is FETCH.
REQ-046 reset driven low in MEMWR between clock edges -> mem_write falls to 0 before the next edge and state=0; after release, mem_req=1.
